ifu_fetch: RTL and testbench
============================

IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter XLEN, default 32, SHALL set the width of addresses and instruction words.
REQ-003 Port clk, input, 1, SHALL be the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: synchronous and active-high.
REQ-005 Port req_valid, output, 1, SHALL indicate an instruction-memory read request.
REQ-006 Port req_ready, input, 1, SHALL indicate memory accepts the request this cycle.
REQ-007 Port req_addr, output, XLEN, SHALL carry the fetch address; it equals the pc register.
REQ-008 Port resp_valid, input, 1, SHALL mark resp_data valid for one cycle.
REQ-009 Port resp_data, input, XLEN, SHALL carry the fetched instruction word.
REQ-010 Port inst_valid, output, 1, SHALL indicate that inst and inst_pc hold an instruction for decode.
REQ-011 Port inst_ready, input, 1, SHALL indicate decode consumes the instruction this cycle.
REQ-012 Port inst, output, XLEN, SHALL carry the buffered instruction word.
REQ-013 Port inst_pc, output, XLEN, SHALL carry the address of inst.
REQ-014 Port redirect_valid, input, 1, SHALL request a fetch-stream restart from a taken branch or jump.
REQ-015 Port redirect_pc, input, XLEN, SHALL carry the restart target.
REQ-016 Port halt, input, 1, SHALL request a permanent fetch stop (ebreak retired).
REQ-017 Port halted, output, 1, SHALL be high while in state HALTED.

Function
REQ-018 The block SHALL implement states REQ, WAIT, OUT and HALTED; all outputs SHALL be decoded from registered state only (no input-to-output combinational paths).
REQ-019 In REQ: req_valid=1; on req_ready SHALL move to WAIT; otherwise SHALL stay in REQ with req_addr held stable.
REQ-020 In WAIT: on resp_valid with drop=0, SHALL latch resp_data into inst and pc into inst_pc, then move to OUT.
REQ-021 In WAIT: on resp_valid with drop=1, SHALL discard the data, clear drop and move to REQ.
REQ-022 In OUT: inst_valid=1; on inst_ready, SHALL set pc <= pc + 4 (modulo 2^XLEN, wrapping 32'hFFFF_FFFC to 0) and move to REQ.
REQ-023 Exactly one memory request SHALL be outstanding at a time; req_valid and inst_valid SHALL never both be high.
REQ-024 A redirect SHALL always load pc <= redirect_pc, and SHALL take priority over every other event except halt and rst.
REQ-025 On a redirect in REQ without req_ready, the block SHALL stay in REQ; the next req_addr SHALL be redirect_pc.
REQ-026 On a redirect in REQ with req_ready, or in WAIT without resp_valid, the block SHALL set drop=1 and be in WAIT next cycle.
REQ-027 On a redirect in WAIT with resp_valid, the block SHALL discard the response and move to REQ with drop=0.
REQ-028 On a redirect in OUT, the block SHALL discard the buffered instruction even if inst_ready=1, and move to REQ; pc SHALL NOT be incremented.
REQ-029 When halt=1 in any state, the block SHALL enter HALTED next cycle; in HALTED, req_valid=0 and inst_valid=0, and responses and redirects SHALL be ignored.
REQ-030 Only rst SHALL leave HALTED.

Reset
REQ-031 While rst=1 the block SHALL enter REQ with pc=RESET_PC, drop=0, inst=0 and inst_pc=0; rst SHALL override halt and redirect.
REQ-032 The first cycle after reset SHALL show req_valid=1, req_addr=RESET_PC, inst_valid=0 and halted=0.
REQ-033 Reset asserted mid-transaction SHALL abandon the outstanding request, and SHALL NOT set drop.

Verification
REQ-034 Test 1, streaming: reset; memory ready=1 with 1-cycle response 32'h0000_0013. Required: inst_pc sequence 8000_0000, 8000_0004, 8000_0008, one instruction every 3 cycles.
REQ-035 Test 2, backpressure: hold inst_ready=0 for 5 cycles in OUT. Required: inst and inst_pc stable, req_valid=0 throughout, and pc advances only after inst_ready.
REQ-036 Test 3, redirect in WAIT: redirect_pc=8000_0100 while the response is pending. Required: the stale response is dropped, the next req_addr is 8000_0100, and no stale inst_valid appears.
REQ-037 Test 4, redirect and inst_ready together in OUT: the instruction is not counted; the next req_addr equals redirect_pc, not pc+4.
REQ-038 Test 5, halt: halt=1 in WAIT followed by resp_valid. Required: halted=1 next cycle, and no req_valid or inst_valid afterwards until rst.
REQ-039 Test 6, wrap and reset mid-WAIT: pc=FFFF_FFFC consumed, so the next req_addr=0000_0000; rst in WAIT gives req_addr=8000_0000 next cycle.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if -- bundle of every non-clock signal of the instruction fetch unit.
//   memory side : req_valid/req_ready/req_addr, resp_valid/resp_data
//   decode side : inst_valid/inst_ready/inst/inst_pc
//   control     : redirect_valid/redirect_pc, halt, halted
// Modport master is the fetch unit's view; slave is the view of its environment.
interface ifu_fetch_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            halt;
    logic            halted;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, halted,
        input  req_ready, resp_valid, resp_data, inst_ready,
               redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, halted,
        output req_ready, resp_valid, resp_data, inst_ready,
               redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch -- single-outstanding-request instruction fetch unit.
// Issues one memory read at pc, buffers the returned word for decode, then
// advances pc by 4. Redirects restart the stream (a response already in flight
// is dropped), halt stops fetching until reset.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : ifu_fetch_if master modport (memory, decode and control signals)
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_REQ    | presenting req_addr=pc, waiting for req_ready
// S_WAIT   | request accepted, waiting for resp_valid (dropped if drop=1)
// S_OUT    | instruction buffered, inst_valid high until inst_ready
// S_HALTED | fetch stopped; only rst leaves
module ifu_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic         clk,
    input  logic         rst,
    ifu_fetch_if.master  bus
);
    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_OUT    = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            drop, drop_n;
    logic [XLEN-1:0] inst_q, inst_n;
    logic [XLEN-1:0] inst_pc_q, inst_pc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            drop      <= drop_n;
            inst_q    <= inst_n;
            inst_pc_q <= inst_pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        drop_n    = drop;
        inst_n    = inst_q;
        inst_pc_n = inst_pc_q;
        if (bus.halt) begin
            state_n = S_HALTED;
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.redirect_valid) begin
                        pc_n = bus.redirect_pc;
                        // Request at the old pc was accepted: its response must be dropped.
                        if (bus.req_ready) begin
                            state_n = S_WAIT;
                            drop_n  = 1'b1;
                        end
                    end else if (bus.req_ready) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.redirect_valid) begin
                        pc_n = bus.redirect_pc;
                        if (bus.resp_valid) begin
                            state_n = S_REQ;
                            drop_n  = 1'b0;
                        end else begin
                            drop_n  = 1'b1;
                        end
                    end else if (bus.resp_valid) begin
                        if (drop) begin
                            state_n = S_REQ;
                            drop_n  = 1'b0;
                        end else begin
                            inst_n    = bus.resp_data;
                            inst_pc_n = pc;
                            state_n   = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.redirect_valid) begin
                        pc_n    = bus.redirect_pc;
                        state_n = S_REQ;
                    end else if (bus.inst_ready) begin
                        pc_n    = pc + XLEN'(4);
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_HALTED;
            endcase
        end
    end

    assign bus.req_valid  = (state == S_REQ);
    assign bus.req_addr   = pc;
    assign bus.inst_valid = (state == S_OUT);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.halted     = (state == S_HALTED);
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch -- directed self-checking bench for ifu_fetch.
module tb_ifu_fetch;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ifu_fetch_if #(.XLEN(32)) bus ();

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From REQ at addr, fetch data and stop in OUT with the instruction presented.
    task automatic go_out(input logic [31:0] addr, input logic [31:0] data);
        check("req_valid_in_req", bus.req_valid, 1);
        check("req_addr_in_req", bus.req_addr, addr);
        check("inst_valid_in_req", bus.inst_valid, 0);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        check("req_valid_in_wait", bus.req_valid, 0);
        check("inst_valid_in_wait", bus.inst_valid, 0);
        bus.resp_valid = 1'b1;
        bus.resp_data  = data;
        tick();
        bus.resp_valid = 1'b0;
        bus.resp_data  = 32'h0;
        check("inst_valid_in_out", bus.inst_valid, 1);
        check("req_valid_in_out", bus.req_valid, 0);
        check("inst", bus.inst, data);
        check("inst_pc", bus.inst_pc, addr);
    endtask

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data);
        go_out(addr, data);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("next_req_addr", bus.req_addr, addr + 32'd4);
        check("req_valid_after_consume", bus.req_valid, 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data = 32'h0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("rst_req_valid", bus.req_valid, 1);
        check("rst_req_addr", bus.req_addr, 32'h8000_0000);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_pc", bus.inst_pc, 32'h0);

        // streaming, one instruction every 3 cycles
        fetch_one(32'h8000_0000, 32'h0000_0013);
        fetch_one(32'h8000_0004, 32'h0000_0013);
        fetch_one(32'h8000_0008, 32'h0000_0013);

        // backpressure in OUT
        go_out(32'h8000_000C, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_inst_valid", bus.inst_valid, 1);
            check("bp_req_valid", bus.req_valid, 0);
            check("bp_inst", bus.inst, 32'hDEAD_BEEF);
            check("bp_inst_pc", bus.inst_pc, 32'h8000_000C);
            check("bp_pc_held", bus.req_addr, 32'h8000_000C);
        end
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("bp_pc_advance", bus.req_addr, 32'h8000_0010);

        // redirect in WAIT without response: stale response dropped
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        check("rw_still_wait", bus.req_valid, 0);
        check("rw_no_inst", bus.inst_valid, 0);
        bus.resp_valid = 1'b1;
        bus.resp_data = 32'hBAD0_BAD0;
        tick();
        bus.resp_valid = 1'b0;
        check("rw_stale_dropped", bus.inst_valid, 0);
        check("rw_req_valid", bus.req_valid, 1);
        check("rw_req_addr", bus.req_addr, 32'h8000_0100);
        fetch_one(32'h8000_0100, 32'h0000_0033);

        // redirect in WAIT together with response: dropped, drop stays clear
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0180;
        bus.resp_valid = 1'b1;
        bus.resp_data = 32'hBAD1_BAD1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.resp_valid = 1'b0;
        check("rwr_inst_valid", bus.inst_valid, 0);
        check("rwr_req_addr", bus.req_addr, 32'h8000_0180);
        fetch_one(32'h8000_0180, 32'h0000_0093);

        // redirect and inst_ready together in OUT
        go_out(32'h8000_0184, 32'h0000_0113);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0200;
        bus.inst_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready = 1'b0;
        check("ro_req_valid", bus.req_valid, 1);
        check("ro_inst_valid", bus.inst_valid, 0);
        check("ro_req_addr", bus.req_addr, 32'h8000_0200);

        // redirect in REQ without req_ready
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0300;
        tick();
        bus.redirect_valid = 1'b0;
        check("rr_req_valid", bus.req_valid, 1);
        check("rr_req_addr", bus.req_addr, 32'h8000_0300);

        // redirect in REQ with req_ready: old request's response dropped
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0400;
        bus.req_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.req_ready = 1'b0;
        check("rrr_in_wait", bus.req_valid, 0);
        bus.resp_valid = 1'b1;
        bus.resp_data = 32'hBAD2_BAD2;
        tick();
        bus.resp_valid = 1'b0;
        check("rrr_dropped", bus.inst_valid, 0);
        check("rrr_req_addr", bus.req_addr, 32'h8000_0400);
        check("rrr_req_valid", bus.req_valid, 1);

        // pc wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        go_out(32'hFFFF_FFFC, 32'h0000_0073);
        bus.inst_ready = 1'b1;
        tick();
        bus.inst_ready = 1'b0;
        check("wrap_req_addr", bus.req_addr, 32'h0000_0000);

        // reset mid-WAIT
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_req_valid", bus.req_valid, 1);
        check("rstw_req_addr", bus.req_addr, 32'h8000_0000);
        fetch_one(32'h8000_0000, 32'h0000_0013);

        // halt in WAIT followed by response and redirect
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("halt_halted", bus.halted, 1);
        check("halt_req_valid", bus.req_valid, 0);
        check("halt_inst_valid", bus.inst_valid, 0);
        bus.resp_valid = 1'b1;
        bus.resp_data = 32'h0000_0013;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0500;
        bus.req_ready = 1'b1;
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hl_halted", bus.halted, 1);
            check("hl_req_valid", bus.req_valid, 0);
            check("hl_inst_valid", bus.inst_valid, 0);
        end
        bus.resp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.inst_ready = 1'b0;

        // rst overrides halt and leaves HALTED
        rst = 1'b1;
        bus.halt = 1'b1;
        tick();
        rst = 1'b0;
        bus.halt = 1'b0;
        check("rh_halted", bus.halted, 0);
        check("rh_req_valid", bus.req_valid, 1);
        check("rh_req_addr", bus.req_addr, 32'h8000_0000);
        check("rh_inst_pc", bus.inst_pc, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
